// File: rtl/crypto_sha256_fu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : crypto_sha256_fu_pkg
// Description : Shared definitions for the SHA-256 functional unit.
//               Holds the datapath width, tag width, op encoding, the
//               buffered result entry type and the 32-bit rotate helper.
// Revision    : 1.0 - initial release
// ============================================================================
package crypto_sha256_fu_pkg;

  // Datapath width: 32 or 64. On 64-bit machines the 32-bit SHA results are
  // sign-extended from bit 31.
  localparam int XLEN          = 64;
  localparam int TRANS_ID_BITS = 3;

  typedef enum logic [1:0] {
    SHA256_SUM0 = 2'd0,
    SHA256_SUM1 = 2'd1,
    SHA256_SIG0 = 2'd2,
    SHA256_SIG1 = 2'd3
  } sha256_op_e;

  typedef struct packed {
    logic [XLEN-1:0]          result;
    logic [TRANS_ID_BITS-1:0] trans_id;
  } sha256_entry_t;

  // Rotate right on a 32-bit word; n is always a constant 1..31 here.
  function automatic logic [31:0] ror32(input logic [31:0] x, input int unsigned n);
    return (x >> n) | (x << (32 - n));
  endfunction

endpackage
`default_nettype wire

// File: rtl/crypto_sha256_fu_result_fifo.sv
`default_nettype none
// ============================================================================
// Module      : crypto_result_fifo
// Description : Small circular buffer of tagged SHA-256 results between the
//               evaluation stage and the writeback port.
// Revision    : 1.0 - initial release
//
// Ports:
//   clk_i      in   clock
//   rst_ni     in   synchronous active-low reset (buffer empty)
//   flush_i    in   discard all entries; beats same-cycle push and pop
//   push_i     in   write push_data_i at the tail
//   push_data_i in  entry to write
//   pop_i      in   consume the head entry
//   count_o    out  number of valid entries (0..DEPTH)
//   empty_o    out  no valid entries
//   head_o     out  head entry, all zero when empty
// ============================================================================
module crypto_result_fifo
  import crypto_sha256_fu_pkg::*;
#(
  parameter  int DEPTH = 3,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              flush_i,
  input  logic              push_i,
  input  sha256_entry_t     push_data_i,
  input  logic              pop_i,
  output logic [CNT_W-1:0]  count_o,
  output logic              empty_o,
  output sha256_entry_t     head_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  sha256_entry_t    mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             full;
  logic             empty;
  logic             do_push;
  logic             do_pop;

  // Pointers wrap at DEPTH, which need not be a power of two.
  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop_i && !empty;
  // A push into a full buffer is only safe when the head leaves this cycle.
  assign do_push = push_i && (!full || do_pop);

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= next_ptr(wr_ptr);
      if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: entries are only visible through count.
  always_ff @(posedge clk_i) begin
    if (rst_ni && !flush_i && do_push) begin
      mem[wr_ptr] <= push_data_i;
    end
  end

  assign count_o = count;
  assign empty_o = empty;
  assign head_o  = empty ? '0 : mem[rd_ptr];

endmodule
`default_nettype wire

// File: rtl/crypto_sha256_fu.sv
`default_nettype none
// ============================================================================
// Module      : crypto_sha256_fu
// Description : Pipelined SHA-256 sigma/sum functional unit. Stage S1
//               registers the issued op; stage S2 evaluates it
//               combinationally and pushes the tagged result into a small
//               buffer so writeback backpressure never stalls evaluation.
// Revision    : 1.0 - initial release
//
// Ports:
//   clk_i           in   clock
//   rst_ni          in   synchronous active-low reset
//   flush_i         in   kill all in-flight and buffered ops
//   valid_i         in   issue offers an op
//   ready_o         out  unit can accept this cycle (registered state only)
//   op_i            in   0=SUM0 1=SUM1 2=SIG0 3=SIG1
//   rs1_i           in   source operand, only [31:0] used
//   trans_id_i      in   scoreboard tag
//   result_valid_o  out  buffer head valid
//   result_ready_i  in   writeback consumes head
//   result_o        out  head result (0 when empty)
//   trans_id_o      out  head tag (0 when empty)
// ============================================================================
module crypto_sha256_fu
  import crypto_sha256_fu_pkg::*;
#(
  parameter int FIFO_DEPTH = 3
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     flush_i,
  input  logic                     valid_i,
  output logic                     ready_o,
  input  logic [1:0]               op_i,
  input  logic [XLEN-1:0]          rs1_i,
  input  logic [TRANS_ID_BITS-1:0] trans_id_i,
  output logic                     result_valid_o,
  input  logic                     result_ready_i,
  output logic [XLEN-1:0]          result_o,
  output logic [TRANS_ID_BITS-1:0] trans_id_o
);

  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  // S1 registers
  logic                     s1_valid;
  sha256_op_e               s1_op;
  logic [31:0]              s1_x;
  logic [TRANS_ID_BITS-1:0] s1_tag;

  logic                     accept;
  logic [CNT_W-1:0]         fifo_count;
  logic                     fifo_empty;
  logic [CNT_W:0]           occupancy;
  logic [31:0]              sha_result;
  logic [XLEN-1:0]          result_ext;
  sha256_entry_t            push_entry;
  sha256_entry_t            head_entry;

  // Ready counts the op sitting in S1 as already occupying a buffer slot, so
  // the buffer can never overflow and ready never depends on this cycle's
  // inputs.
  assign occupancy = {1'b0, fifo_count} + {{CNT_W{1'b0}}, s1_valid};
  assign ready_o   = (occupancy < (CNT_W + 1)'(FIFO_DEPTH));
  assign accept    = valid_i && ready_o && !flush_i;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      s1_valid <= 1'b0;
      s1_op    <= SHA256_SUM0;
      s1_x     <= '0;
      s1_tag   <= '0;
    end else if (flush_i) begin
      s1_valid <= 1'b0;
    end else begin
      s1_valid <= accept;
      if (accept) begin
        s1_op  <= sha256_op_e'(op_i);
        s1_x   <= rs1_i[31:0];
        s1_tag <= trans_id_i;
      end
    end
  end

  // S2: sigma/sum evaluation on the S1 operand
  always_comb begin
    sha_result = '0;
    case (s1_op)
      SHA256_SUM0: sha_result = ror32(s1_x, 2)  ^ ror32(s1_x, 13) ^ ror32(s1_x, 22);
      SHA256_SUM1: sha_result = ror32(s1_x, 6)  ^ ror32(s1_x, 11) ^ ror32(s1_x, 25);
      SHA256_SIG0: sha_result = ror32(s1_x, 7)  ^ ror32(s1_x, 18) ^ (s1_x >> 3);
      SHA256_SIG1: sha_result = ror32(s1_x, 17) ^ ror32(s1_x, 19) ^ (s1_x >> 10);
      default:     sha_result = '0;
    endcase
  end

  generate
    if (XLEN > 32) begin : g_xlen_wide
      assign result_ext = {{(XLEN - 32){sha_result[31]}}, sha_result};
      // Upper operand bits are architecturally ignored.
      logic unused_rs1_hi;
      assign unused_rs1_hi = ^rs1_i[XLEN-1:32];
    end else begin : g_xlen32
      assign result_ext = sha_result;
    end
  endgenerate

  assign push_entry.result   = result_ext;
  assign push_entry.trans_id = s1_tag;

  crypto_result_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_result_fifo (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .flush_i     (flush_i),
    .push_i      (s1_valid),
    .push_data_i (push_entry),
    .pop_i       (result_valid_o && result_ready_i),
    .count_o     (fifo_count),
    .empty_o     (fifo_empty),
    .head_o      (head_entry)
  );

  assign result_valid_o = !fifo_empty;
  assign result_o       = head_entry.result;
  assign trans_id_o     = head_entry.trans_id;

endmodule
`default_nettype wire

// File: tb/tb_crypto_sha256_fu.sv
`default_nettype none
// ============================================================================
// Module      : tb_crypto_sha256_fu
// Description : Directed self-checking bench for crypto_sha256_fu.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_crypto_sha256_fu;
  import crypto_sha256_fu_pkg::*;

  localparam int FIFO_DEPTH = 3;

  logic                     clk = 1'b0;
  logic                     rst_ni;
  logic                     flush_i;
  logic                     valid_i;
  logic                     ready_o;
  logic [1:0]               op_i;
  logic [XLEN-1:0]          rs1_i;
  logic [TRANS_ID_BITS-1:0] trans_id_i;
  logic                     result_valid_o;
  logic                     result_ready_i;
  logic [XLEN-1:0]          result_o;
  logic [TRANS_ID_BITS-1:0] trans_id_o;

  int vectors    = 0;
  int miscompares = 0;

  // Hand-computed results for x = 1, indexed by op (SUM0, SUM1, SIG0, SIG1)
  logic [31:0] exp1 [4] = '{32'h40080400, 32'h04200080, 32'h02004000, 32'h0000A000};

  always #5 clk = ~clk;

  crypto_sha256_fu #(
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clk_i          (clk),
    .rst_ni         (rst_ni),
    .flush_i        (flush_i),
    .valid_i        (valid_i),
    .ready_o        (ready_o),
    .op_i           (op_i),
    .rs1_i          (rs1_i),
    .trans_id_i     (trans_id_i),
    .result_valid_o (result_valid_o),
    .result_ready_i (result_ready_i),
    .result_o       (result_o),
    .trans_id_o     (trans_id_o)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [XLEN-1:0] sx(input logic [31:0] v);
    return XLEN'(signed'(v));
  endfunction

  task automatic test_reset();
    rst_ni = 1'b0; flush_i = 1'b0; valid_i = 1'b0; op_i = 2'd0;
    rs1_i = '0; trans_id_i = '0; result_ready_i = 1'b1;
    step(); step();
    vectors++; if (ready_o !== 1'b1) begin miscompares++; $display("FAIL reset_ready got %b want 1", ready_o); end
    vectors++; if (result_valid_o !== 1'b0) begin miscompares++; $display("FAIL reset_rvalid got %b want 0", result_valid_o); end
    vectors++; if (result_o !== '0) begin miscompares++; $display("FAIL reset_result got %h want 0", result_o); end
    vectors++; if (trans_id_o !== '0) begin miscompares++; $display("FAIL reset_tag got %h want 0", trans_id_o); end
    rst_ni = 1'b1;
    step();
  endtask

  task automatic test_single();
    valid_i = 1'b1; op_i = 2'd0; rs1_i = XLEN'(1); trans_id_i = 3'd5; result_ready_i = 1'b1;
    step();
    valid_i = 1'b0;
    vectors++; if (result_valid_o !== 1'b0) begin miscompares++; $display("FAIL single_early got %b want 0", result_valid_o); end
    step();
    vectors++; if (result_valid_o !== 1'b1) begin miscompares++; $display("FAIL single_rvalid got %b want 1", result_valid_o); end
    vectors++; if (result_o !== sx(32'h40080400)) begin miscompares++; $display("FAIL single_result got %h want %h", result_o, sx(32'h40080400)); end
    vectors++; if (trans_id_o !== 3'd5) begin miscompares++; $display("FAIL single_tag got %0d want 5", trans_id_o); end
    step();
    vectors++; if (result_valid_o !== 1'b0) begin miscompares++; $display("FAIL single_one_cycle got %b want 0", result_valid_o); end
  endtask

  task automatic test_back_to_back();
    result_ready_i = 1'b1;
    for (int i = 0; i < 6; i++) begin
      valid_i = (i < 3); op_i = 2'(i + 1); rs1_i = XLEN'(1); trans_id_i = 3'(i + 1);
      vectors++; if (ready_o !== 1'b1) begin miscompares++; $display("FAIL b2b_ready cyc %0d got %b want 1", i, ready_o); end
      if (i >= 2 && i < 5) begin
        vectors++; if (result_valid_o !== 1'b1) begin miscompares++; $display("FAIL b2b_rvalid cyc %0d got %b want 1", i, result_valid_o); end
        vectors++; if (result_o !== sx(exp1[i-1])) begin miscompares++; $display("FAIL b2b_result cyc %0d got %h want %h", i, result_o, sx(exp1[i-1])); end
        vectors++; if (trans_id_o !== 3'(i - 1)) begin miscompares++; $display("FAIL b2b_tag cyc %0d got %0d want %0d", i, trans_id_o, i - 1); end
      end else begin
        vectors++; if (result_valid_o !== 1'b0) begin miscompares++; $display("FAIL b2b_idle cyc %0d got %b want 0", i, result_valid_o); end
      end
      step();
    end
    valid_i = 1'b0;
  endtask

  task automatic test_xlen64();
    valid_i = 1'b1; op_i = 2'd0; rs1_i = XLEN'(64'hDEADBEEF_00000002); trans_id_i = 3'd6;
    result_ready_i = 1'b1;
    step();
    valid_i = 1'b0;
    step();
    vectors++; if (result_valid_o !== 1'b1) begin miscompares++; $display("FAIL x64_rvalid got %b want 1", result_valid_o); end
    vectors++; if (result_o !== sx(32'h80100800)) begin miscompares++; $display("FAIL x64_result got %h want %h", result_o, sx(32'h80100800)); end
    vectors++; if (trans_id_o !== 3'd6) begin miscompares++; $display("FAIL x64_tag got %0d want 6", trans_id_o); end
    step();
  endtask

  task automatic test_backpressure();
    logic [1:0] bp_op [4] = '{2'd3, 2'd0, 2'd2, 2'd0};
    int acc = 0;
    result_ready_i = 1'b0;
    for (int i = 0; i < 6; i++) begin
      valid_i = 1'b1; op_i = bp_op[acc]; rs1_i = XLEN'(1); trans_id_i = 3'(4 + acc);
      vectors++; if (ready_o !== (i < 3)) begin miscompares++; $display("FAIL bp_ready cyc %0d got %b want %b", i, ready_o, (i < 3)); end
      vectors++; if (result_valid_o !== (i >= 2)) begin miscompares++; $display("FAIL bp_rvalid cyc %0d got %b want %b", i, result_valid_o, (i >= 2)); end
      if (ready_o && acc < 3) acc++;
      step();
    end
    valid_i = 1'b0;
    result_ready_i = 1'b1;
    for (int k = 0; k < 3; k++) begin
      vectors++; if (result_valid_o !== 1'b1) begin miscompares++; $display("FAIL bp_drain_rvalid %0d got %b want 1", k, result_valid_o); end
      vectors++; if (result_o !== sx(exp1[bp_op[k]])) begin miscompares++; $display("FAIL bp_drain_result %0d got %h want %h", k, result_o, sx(exp1[bp_op[k]])); end
      vectors++; if (trans_id_o !== 3'(4 + k)) begin miscompares++; $display("FAIL bp_drain_tag %0d got %0d want %0d", k, trans_id_o, 4 + k); end
      step();
    end
    vectors++; if (result_valid_o !== 1'b0) begin miscompares++; $display("FAIL bp_drained got %b want 0", result_valid_o); end
  endtask

  task automatic test_flush();
    // Fill: two results buffered plus one op in S1
    result_ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      valid_i = 1'b1; op_i = 2'd0; rs1_i = XLEN'(1); trans_id_i = 3'(1 + i);
      step();
    end
    vectors++; if (ready_o !== 1'b0) begin miscompares++; $display("FAIL flush_pre_ready got %b want 0", ready_o); end
    flush_i = 1'b1; valid_i = 1'b1; op_i = 2'd1; trans_id_i = 3'd7; result_ready_i = 1'b1;
    step();
    flush_i = 1'b0; valid_i = 1'b0;
    vectors++; if (result_valid_o !== 1'b0) begin miscompares++; $display("FAIL flush_rvalid got %b want 0", result_valid_o); end
    vectors++; if (ready_o !== 1'b1) begin miscompares++; $display("FAIL flush_ready got %b want 1", ready_o); end
    step();
    vectors++; if (result_valid_o !== 1'b0) begin miscompares++; $display("FAIL flush_s1_killed got %b want 0", result_valid_o); end
    // Flush against an accept the unit would otherwise take
    valid_i = 1'b1; flush_i = 1'b1; op_i = 2'd0; trans_id_i = 3'd2;
    step();
    valid_i = 1'b0; flush_i = 1'b0;
    step();
    vectors++; if (result_valid_o !== 1'b0) begin miscompares++; $display("FAIL flush_accept_dropped got %b want 0", result_valid_o); end
    // Unit still works afterwards
    valid_i = 1'b1; op_i = 2'd3; rs1_i = XLEN'(1); trans_id_i = 3'd7;
    step();
    valid_i = 1'b0;
    step();
    vectors++; if (result_o !== sx(32'h0000A000)) begin miscompares++; $display("FAIL flush_after_result got %h want %h", result_o, sx(32'h0000A000)); end
    vectors++; if (trans_id_o !== 3'd7) begin miscompares++; $display("FAIL flush_after_tag got %0d want 7", trans_id_o); end
    step();
  endtask

  task automatic test_reset_mid();
    result_ready_i = 1'b0;
    for (int i = 0; i < 2; i++) begin
      valid_i = 1'b1; op_i = 2'(i); rs1_i = XLEN'(1); trans_id_i = 3'(1 + i);
      step();
    end
    vectors++; if (result_valid_o !== 1'b1) begin miscompares++; $display("FAIL rstmid_pre got %b want 1", result_valid_o); end
    rst_ni = 1'b0; valid_i = 1'b1;
    step();
    rst_ni = 1'b1; valid_i = 1'b0;
    vectors++; if (ready_o !== 1'b1) begin miscompares++; $display("FAIL rstmid_ready got %b want 1", ready_o); end
    vectors++; if (result_valid_o !== 1'b0) begin miscompares++; $display("FAIL rstmid_rvalid got %b want 0", result_valid_o); end
    vectors++; if (result_o !== '0) begin miscompares++; $display("FAIL rstmid_result got %h want 0", result_o); end
    vectors++; if (trans_id_o !== '0) begin miscompares++; $display("FAIL rstmid_tag got %0d want 0", trans_id_o); end
    step();
    vectors++; if (result_valid_o !== 1'b0) begin miscompares++; $display("FAIL rstmid_s1_lost got %b want 0", result_valid_o); end
    result_ready_i = 1'b1;
    valid_i = 1'b1; op_i = 2'd1; rs1_i = XLEN'(1); trans_id_i = 3'd3;
    step();
    valid_i = 1'b0;
    vectors++; if (result_valid_o !== 1'b0) begin miscompares++; $display("FAIL rstmid_early got %b want 0", result_valid_o); end
    step();
    vectors++; if (result_valid_o !== 1'b1) begin miscompares++; $display("FAIL rstmid_after_rvalid got %b want 1", result_valid_o); end
    vectors++; if (result_o !== sx(32'h04200080)) begin miscompares++; $display("FAIL rstmid_after_result got %h want %h", result_o, sx(32'h04200080)); end
    vectors++; if (trans_id_o !== 3'd3) begin miscompares++; $display("FAIL rstmid_after_tag got %0d want 3", trans_id_o); end
    step();
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_xlen64();
    test_backpressure();
    test_flush();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
